vec_mem_sequencer: RTL and testbench

//  Parametrised vector load/store sequencer for the CVP vector core. Takes one

---
 rtl/vec_mem_sequencer.sv | 170 +++++++++++++++++
 tb/tb_vec_mem_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_mem_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : vec_mem_sequencer
//  Description : Vector load/store sequencer for the CVP vector core. Accepts
//                one vector memory request (base, element count, store data)
//                and runs per-element RD/WR bus cycles on the 16-bit memory
//                bus. It stalls on MemRdy and finishes with a one-cycle
//                done_valid pulse.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    Clk1, Reset        clock / synchronous active-high reset
//    req_valid/ready    request handshake; ready only while idle
//    req_store          1 = store, 0 = load
//    req_base           address of element 0
//    req_len            element count minus 1
//    req_wdata          store data, element i at [i*ELEM_W +: ELEM_W]
//    Addr, RD, WR       memory bus address and strobes
//    dataOut            store data to memory
//    DataIn             read data, valid the cycle after an accepted RD
//    MemRdy             memory accepts the strobe presented this cycle
//    done_valid         one-cycle completion pulse
//    done_vector        assembled load vector, held until next load accept
//    V                  some issued address wrapped past all-ones
// ============================================================================
module vec_mem_sequencer #(
    parameter  int ELEM_W = 16,
    parameter  int LANES  = 16,
    parameter  int ADDR_W = 16,
    localparam int LEN_W  = $clog2(LANES)
) (
    input  logic                    Clk1,
    input  logic                    Reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_store,
    input  logic [ADDR_W-1:0]       req_base,
    input  logic [LEN_W-1:0]        req_len,
    input  logic [LANES*ELEM_W-1:0] req_wdata,
    output logic [ADDR_W-1:0]       Addr,
    output logic                    RD,
    output logic                    WR,
    output logic [ELEM_W-1:0]       dataOut,
    input  logic [ELEM_W-1:0]       DataIn,
    input  logic                    MemRdy,
    output logic                    done_valid,
    output logic [LANES*ELEM_W-1:0] done_vector,
    output logic                    V
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_LDRAIN = 3'd2;
    localparam logic [2:0] S_STORE  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]              state;
    logic [2:0]              next_state;

    logic [ADDR_W-1:0]       base;
    logic [LEN_W-1:0]        len;
    logic [LANES*ELEM_W-1:0] wdata;
    logic [LEN_W-1:0]        idx;
    logic                    pend;
    logic [LEN_W-1:0]        pend_idx;

    logic                    accept;
    logic                    busy;
    logic                    last;
    logic [ADDR_W:0]         addr_sum;

    // Carry out of base+idx marks an address that wrapped past all-ones.
    assign addr_sum = {1'b0, base} + (ADDR_W+1)'(idx);
    assign accept   = req_valid & req_ready;
    assign busy     = (state == S_LOAD) || (state == S_STORE);
    assign last     = (idx == len);

    // ---------------------------------------------------------------- state
    always_ff @(posedge Clk1) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    next_state = req_store ? S_STORE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (MemRdy && last) begin
                    next_state = S_LDRAIN;
                end
            end
            S_LDRAIN: next_state = S_DONE;
            S_STORE: begin
                if (MemRdy && last) begin
                    next_state = S_DONE;
                end
            end
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    // Bus outputs depend only on registered state, so a stalled strobe keeps
    // Addr/dataOut stable for as long as MemRdy stays low.
    always_comb begin
        req_ready  = (state == S_IDLE);
        RD         = (state == S_LOAD);
        WR         = (state == S_STORE);
        done_valid = (state == S_DONE);
        Addr       = '0;
        dataOut    = '0;
        if (busy) begin
            Addr = addr_sum[ADDR_W-1:0];
        end
        if (state == S_STORE) begin
            dataOut = wdata[idx*ELEM_W +: ELEM_W];
        end
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge Clk1) begin
        if (Reset) begin
            base        <= '0;
            len         <= '0;
            wdata       <= '0;
            idx         <= '0;
            pend        <= 1'b0;
            pend_idx    <= '0;
            done_vector <= '0;
            V           <= 1'b0;
        end else if (accept) begin
            base     <= req_base;
            len      <= req_len;
            wdata    <= req_wdata;
            idx      <= '0;
            pend     <= 1'b0;
            pend_idx <= '0;
            V        <= 1'b0;
            if (!req_store) begin
                done_vector <= '0;
            end
        end else begin
            // Read data arrives one cycle after its RD was accepted; the
            // final element lands during LDRAIN.
            if (pend) begin
                done_vector[pend_idx*ELEM_W +: ELEM_W] <= DataIn;
            end
            pend <= (state == S_LOAD) && MemRdy;
            if (busy && MemRdy) begin
                idx      <= idx + 1'b1;
                pend_idx <= idx;
            end
            if (busy && addr_sum[ADDR_W]) begin
                V <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vec_mem_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vec_mem_sequencer
//  Description : Directed self-checking bench for vec_mem_sequencer, with a
//                simple memory model: mem[a] = a + 0x10D0.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vec_mem_sequencer;

    logic         Clk1 = 1'b0;
    logic         Reset;
    logic         req_valid;
    logic         req_ready;
    logic         req_store;
    logic [15:0]  req_base;
    logic [3:0]   req_len;
    logic [255:0] req_wdata;
    logic [15:0]  Addr;
    logic         RD;
    logic         WR;
    logic [15:0]  dataOut;
    logic [15:0]  DataIn;
    logic         MemRdy;
    logic         done_valid;
    logic [255:0] done_vector;
    logic         V;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    vec_mem_sequencer #(.ELEM_W(16), .LANES(16), .ADDR_W(16)) dut (
        .Clk1(Clk1), .Reset(Reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_base(req_base), .req_len(req_len), .req_wdata(req_wdata),
        .Addr(Addr), .RD(RD), .WR(WR), .dataOut(dataOut),
        .DataIn(DataIn), .MemRdy(MemRdy),
        .done_valid(done_valid), .done_vector(done_vector), .V(V)
    );

    always #5 Clk1 = ~Clk1;
    always @(posedge Clk1) cyc <= cyc + 1;

    function automatic logic [15:0] mem_val(input logic [15:0] a);
        return a + 16'h10D0;
    endfunction

    // Memory responder: data for an accepted RD appears after that edge.
    always @(posedge Clk1) begin
        if (RD && MemRdy) DataIn <= mem_val(Addr);
    end

    // Capture of one transaction
    logic [15:0] cap_addr[$];
    logic [15:0] cap_dout[$];
    bit          cap_rd[$];
    bit          cap_wr[$];
    bit          cap_rdy[$];
    bit          cap_both;
    bit          cap_timeout;
    bit          cap_noaccept;

    task automatic run_req(input bit st, input logic [15:0] b, input logic [3:0] l,
                           input logic [255:0] wd, input int stalls,
                           output int t0, output int dcyc,
                           output logic [255:0] dvec, output logic dv);
        int s;
        s = stalls;
        cap_addr.delete(); cap_dout.delete(); cap_rd.delete();
        cap_wr.delete(); cap_rdy.delete();
        cap_both = 0; cap_timeout = 1; cap_noaccept = 0;
        dcyc = 0; dvec = '0; dv = 1'b0;
        @(negedge Clk1);
        req_store = st; req_base = b; req_len = l; req_wdata = wd;
        req_valid = 1'b1; MemRdy = 1'b1;
        if (!req_ready) cap_noaccept = 1;
        @(posedge Clk1);
        #1 req_valid = 1'b0;
        t0 = cyc - 1;
        for (int k = 0; k < 200; k++) begin
            @(negedge Clk1);
            if (RD && WR) cap_both = 1;
            if (done_valid) begin
                dcyc = cyc; dvec = done_vector; dv = V;
                MemRdy = 1'b1; cap_timeout = 0;
                break;
            end
            if (RD || WR) begin
                MemRdy = (s > 0) ? 1'b0 : 1'b1;
                if (s > 0) s--;
                cap_addr.push_back(Addr); cap_dout.push_back(dataOut);
                cap_rd.push_back(RD); cap_wr.push_back(WR);
                cap_rdy.push_back(MemRdy);
            end else begin
                MemRdy = 1'b1;
            end
        end
    endtask

    task automatic test_reset;
        Reset = 1'b1; req_valid = 0; req_store = 0; req_base = 0; req_len = 0;
        req_wdata = '0; MemRdy = 1'b1; DataIn = '0;
        repeat (3) @(posedge Clk1);
        #1 Reset = 1'b0;
        @(negedge Clk1);
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", req_ready); end
        n_checks++; if ({RD, WR} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes got %b want 00", {RD, WR}); end
        n_checks++; if (Addr !== 16'h0 || dataOut !== 16'h0) begin n_fail++; $display("FAIL reset_bus got addr %h dout %h want 0 0", Addr, dataOut); end
        n_checks++; if (done_valid !== 1'b0 || V !== 1'b0) begin n_fail++; $display("FAIL reset_done got dv %b V %b want 0 0", done_valid, V); end
        n_checks++; if (done_vector !== 256'h0) begin n_fail++; $display("FAIL reset_vector got %h want 0", done_vector); end
    endtask

    task automatic test_load_basic;
        int t0, dcyc; logic [255:0] dvec, exp; logic dv;
        exp = '0;
        for (int i = 0; i < 4; i++) exp[i*16 +: 16] = 16'h1110 + 16'(i);
        run_req(1'b0, 16'h0040, 4'd3, '0, 0, t0, dcyc, dvec, dv);
        n_checks++; if (cap_timeout || cap_noaccept) begin n_fail++; $display("FAIL load_done got timeout %b noaccept %b want 0 0", cap_timeout, cap_noaccept); end
        n_checks++; if (cap_addr.size() != 4) begin n_fail++; $display("FAIL load_count got %0d want 4", cap_addr.size()); end
        for (int i = 0; i < cap_addr.size() && i < 4; i++) begin
            n_checks++;
            if (cap_addr[i] !== 16'h0040 + 16'(i) || !cap_rd[i] || cap_wr[i]) begin
                n_fail++; $display("FAIL load_addr%0d got %h rd %b wr %b want %h rd 1 wr 0", i, cap_addr[i], cap_rd[i], cap_wr[i], 16'h0040 + 16'(i));
            end
        end
        n_checks++; if (dcyc - t0 != 6) begin n_fail++; $display("FAIL load_latency got %0d want 6", dcyc - t0); end
        n_checks++; if (dvec !== exp) begin n_fail++; $display("FAIL load_vector got %h want %h", dvec, exp); end
        n_checks++; if (dv !== 1'b0 || cap_both) begin n_fail++; $display("FAIL load_v got V %b both %b want 0 0", dv, cap_both); end
    endtask

    task automatic test_store;
        int t0, dcyc; logic [255:0] wd, dvec; logic dv;
        for (int i = 0; i < 16; i++) wd[i*16 +: 16] = 16'(i * 3);
        run_req(1'b1, 16'h0100, 4'd15, wd, 0, t0, dcyc, dvec, dv);
        n_checks++; if (cap_timeout || cap_noaccept) begin n_fail++; $display("FAIL store_done got timeout %b noaccept %b want 0 0", cap_timeout, cap_noaccept); end
        n_checks++; if (cap_addr.size() != 16) begin n_fail++; $display("FAIL store_count got %0d want 16", cap_addr.size()); end
        for (int i = 0; i < cap_addr.size() && i < 16; i++) begin
            n_checks++;
            if (cap_addr[i] !== 16'h0100 + 16'(i) || cap_dout[i] !== 16'(i * 3) || !cap_wr[i] || cap_rd[i]) begin
                n_fail++; $display("FAIL store_elem%0d got addr %h dout %h wr %b want %h %h wr 1", i, cap_addr[i], cap_dout[i], cap_wr[i], 16'h0100 + 16'(i), 16'(i * 3));
            end
        end
        n_checks++; if (dcyc - t0 != 17) begin n_fail++; $display("FAIL store_latency got %0d want 17", dcyc - t0); end
        n_checks++; if (cap_both) begin n_fail++; $display("FAIL store_strobes got both %b want 0", cap_both); end
    endtask

    task automatic test_wait_states;
        int t0, dcyc; logic [255:0] dvec, exp; logic dv;
        exp = '0;
        exp[15:0]  = mem_val(16'h0200);
        exp[31:16] = mem_val(16'h0201);
        run_req(1'b0, 16'h0200, 4'd1, '0, 2, t0, dcyc, dvec, dv);
        n_checks++; if (cap_addr.size() != 4) begin n_fail++; $display("FAIL wait_count got %0d want 4", cap_addr.size()); end
        else begin
            n_checks++;
            if (cap_addr[0] !== 16'h0200 || cap_addr[1] !== 16'h0200 || cap_addr[2] !== 16'h0200 ||
                cap_addr[3] !== 16'h0201 || !cap_rd[1] || !cap_rd[2] || cap_rdy[0] || cap_rdy[1] || !cap_rdy[2]) begin
                n_fail++; $display("FAIL wait_hold got %h %h %h %h want 0200 0200 0200 0201", cap_addr[0], cap_addr[1], cap_addr[2], cap_addr[3]);
            end
        end
        n_checks++; if (dcyc - t0 != 6) begin n_fail++; $display("FAIL wait_latency got %0d want 6", dcyc - t0); end
        n_checks++; if (dvec !== exp) begin n_fail++; $display("FAIL wait_vector got %h want %h", dvec, exp); end
    endtask

    task automatic test_wrap;
        int t0, dcyc; logic [255:0] dvec, exp; logic dv;
        logic [15:0] ea [4];
        ea[0] = 16'hFFFE; ea[1] = 16'hFFFF; ea[2] = 16'h0000; ea[3] = 16'h0001;
        exp = '0;
        for (int i = 0; i < 4; i++) exp[i*16 +: 16] = mem_val(ea[i]);
        run_req(1'b0, 16'hFFFE, 4'd3, '0, 0, t0, dcyc, dvec, dv);
        n_checks++; if (cap_addr.size() != 4) begin n_fail++; $display("FAIL wrap_count got %0d want 4", cap_addr.size()); end
        for (int i = 0; i < cap_addr.size() && i < 4; i++) begin
            n_checks++; if (cap_addr[i] !== ea[i]) begin n_fail++; $display("FAIL wrap_addr%0d got %h want %h", i, cap_addr[i], ea[i]); end
        end
        n_checks++; if (dv !== 1'b1) begin n_fail++; $display("FAIL wrap_v got %b want 1", dv); end
        n_checks++; if (dvec !== exp) begin n_fail++; $display("FAIL wrap_vector got %h want %h", dvec, exp); end
        run_req(1'b0, 16'h0010, 4'd0, '0, 0, t0, dcyc, dvec, dv);
        n_checks++; if (dv !== 1'b0) begin n_fail++; $display("FAIL wrap_vclear got %b want 0", dv); end
        n_checks++; if (dcyc - t0 != 3) begin n_fail++; $display("FAIL single_latency got %0d want 3", dcyc - t0); end
        n_checks++; if (dvec !== {240'h0, mem_val(16'h0010)}) begin n_fail++; $display("FAIL single_vector got %h want %h", dvec, mem_val(16'h0010)); end
    endtask

    task automatic test_reset_mid_store;
        int t0, dcyc; logic [255:0] wd, dvec, exp; logic dv; bit hit; bit seen_done;
        for (int i = 0; i < 16; i++) wd[i*16 +: 16] = 16'hA000 + 16'(i);
        hit = 0; seen_done = 0;
        @(negedge Clk1);
        req_store = 1'b1; req_base = 16'h0300; req_len = 4'd10; req_wdata = wd;
        req_valid = 1'b1; MemRdy = 1'b1;
        @(posedge Clk1);
        #1 req_valid = 1'b0;
        for (int k = 0; k < 20 && !hit; k++) begin
            @(negedge Clk1);
            if (WR && Addr === 16'h0305) begin
                hit = 1;
                Reset = 1'b1;
                @(posedge Clk1);
                #1 Reset = 1'b0;
            end
        end
        n_checks++; if (!hit) begin n_fail++; $display("FAIL rst_reach got element5 %b want 1", hit); end
        @(negedge Clk1);
        n_checks++; if (WR !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_abort got WR %b ready %b want 0 1", WR, req_ready); end
        for (int k = 0; k < 4; k++) begin
            if (done_valid) seen_done = 1;
            @(negedge Clk1);
        end
        n_checks++; if (seen_done) begin n_fail++; $display("FAIL rst_nodone got done %b want 0", seen_done); end
        exp = '0;
        for (int i = 0; i < 3; i++) exp[i*16 +: 16] = mem_val(16'h0050 + 16'(i));
        run_req(1'b0, 16'h0050, 4'd2, '0, 0, t0, dcyc, dvec, dv);
        n_checks++; if (cap_timeout || dcyc - t0 != 5) begin n_fail++; $display("FAIL rst_reload_latency got %0d timeout %b want 5", dcyc - t0, cap_timeout); end
        n_checks++; if (dvec !== exp) begin n_fail++; $display("FAIL rst_reload_vector got %h want %h", dvec, exp); end
    endtask

    task automatic test_back_to_back;
        bit found;
        found = 0;
        @(negedge Clk1);
        req_store = 1'b0; req_base = 16'h0060; req_len = 4'd0; req_wdata = '0;
        req_valid = 1'b1; MemRdy = 1'b1;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge Clk1);
            if (done_valid) found = 1;
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL b2b_done got done %b want 1", found); end
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_in_done got %b want 0", req_ready); end
        @(negedge Clk1);
        n_checks++; if (req_ready !== 1'b1 || RD !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got ready %b RD %b want 1 0", req_ready, RD); end
        @(negedge Clk1);
        req_valid = 1'b0;
        n_checks++; if (RD !== 1'b1 || Addr !== 16'h0060) begin n_fail++; $display("FAIL b2b_second got RD %b addr %h want 1 0060", RD, Addr); end
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge Clk1);
            if (done_valid) found = 1;
        end
        n_checks++; if (!found || done_vector !== {240'h0, mem_val(16'h0060)}) begin n_fail++; $display("FAIL b2b_second_done got found %b vec %h want 1 %h", found, done_vector, mem_val(16'h0060)); end
    endtask

    initial begin
        test_reset();
        test_load_basic();
        test_store();
        test_wait_states();
        test_wrap();
        test_reset_mid_store();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
